// File: rtl/pspin_feedback_arb_if.sv
// Feedback bus between the cluster sources, the arbiter and the packet allocator.
// master = arbiter view, slave = environment (sources + allocator) view.
interface pspin_feedback_arb_if #(
  parameter int NUM_SRC     = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int LEN_WIDTH   = 20,
  parameter int MSGID_WIDTH = 10
);
  logic [NUM_SRC-1:0]             fb_valid_i;
  logic [NUM_SRC-1:0]             fb_ready_o;
  logic [NUM_SRC*ADDR_WIDTH-1:0]  fb_her_addr_i;
  logic [NUM_SRC*LEN_WIDTH-1:0]   fb_her_size_i;
  logic [NUM_SRC*MSGID_WIDTH-1:0] fb_msgid_i;

  logic                   feedback_valid_o;
  logic                   feedback_ready_i;
  logic [ADDR_WIDTH-1:0]  feedback_her_addr_o;
  logic [LEN_WIDTH-1:0]   feedback_her_size_o;
  logic [MSGID_WIDTH-1:0] feedback_msgid_o;

  modport master (
    input  fb_valid_i, fb_her_addr_i, fb_her_size_i, fb_msgid_i, feedback_ready_i,
    output fb_ready_o, feedback_valid_o, feedback_her_addr_o, feedback_her_size_o,
           feedback_msgid_o
  );

  modport slave (
    output fb_valid_i, fb_her_addr_i, fb_her_size_i, fb_msgid_i, feedback_ready_i,
    input  fb_ready_o, feedback_valid_o, feedback_her_addr_o, feedback_her_size_o,
           feedback_msgid_o
  );
endinterface

// File: rtl/pspin_feedback_arb.sv
// Round-robin arbiter for buffer-release feedback: validates each entry against the
// slot layout, forwards good ones through a one-entry register, counts rejects and in-flight buffers.
module pspin_feedback_arb #(
  parameter int              NUM_SRC           = 4,
  parameter int              ADDR_WIDTH        = 32,
  parameter int              LEN_WIDTH         = 20,
  parameter int              MSGID_WIDTH       = 10,
  parameter int              INFLIGHT_WIDTH    = 32,
  parameter longint unsigned BUF_START         = 64'h1c10_0000,
  parameter int unsigned     SLOT0_SIZE        = 1536,
  parameter int unsigned     SLOT0_COUNT       = 1024,
  parameter int unsigned     SLOT1_SIZE        = 64,
  parameter int unsigned     SLOT1_COUNT       = 8192,
  parameter int unsigned     PKT_MEM_ALIGNMENT = 64
) (
  input  logic                      clk,
  input  logic                      rstn,
  pspin_feedback_arb_if.master      bus,
  input  logic                      alloc_i,
  output logic [INFLIGHT_WIDTH-1:0] inflight_o,
  output logic [31:0]               rejected_o,
  output logic                      underflow_o
);

  localparam int RR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  // Slot ranges computed in 64 bits so the end of SLOT1 cannot wrap the address width.
  localparam longint unsigned S0_LO = BUF_START;
  localparam longint unsigned S1_LO = S0_LO + longint'(SLOT0_COUNT) * longint'(SLOT0_SIZE);
  localparam longint unsigned S1_HI = S1_LO + longint'(SLOT1_COUNT) * longint'(SLOT1_SIZE);

  logic [RR_W-1:0]        rr_q;
  logic [RR_W-1:0]        grant;
  logic                   grant_found;
  logic                   take;
  logic                   hs;
  logic                   fwd;
  logic                   entry_ok;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [LEN_WIDTH-1:0]   sel_size;
  logic [MSGID_WIDTH-1:0] sel_msgid;

  logic                   out_valid_q;
  logic [ADDR_WIDTH-1:0]  out_addr_q;
  logic [LEN_WIDTH-1:0]   out_size_q;
  logic [MSGID_WIDTH-1:0] out_msgid_q;

  logic [INFLIGHT_WIDTH-1:0] inflight_q;
  logic [31:0]               rejected_q;
  logic                      underflow_q;

  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant       = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(rr_q) + k) % NUM_SRC;
      if (!grant_found && bus.fb_valid_i[idx]) begin
        grant_found = 1'b1;
        grant       = RR_W'(idx);
      end
    end
  end

  assign take      = !out_valid_q || bus.feedback_ready_i;
  assign hs        = grant_found && take;
  assign fwd       = out_valid_q && bus.feedback_ready_i;
  assign sel_addr  = bus.fb_her_addr_i[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_size  = bus.fb_her_size_i[int'(grant)*LEN_WIDTH +: LEN_WIDTH];
  assign sel_msgid = bus.fb_msgid_i[int'(grant)*MSGID_WIDTH +: MSGID_WIDTH];

  always_comb begin
    bus.fb_ready_o = '0;
    if (hs) bus.fb_ready_o[grant] = 1'b1;
  end

  always_comb begin
    logic [63:0] a64;
    logic        slot0_hit;
    logic        slot1_hit;
    logic        aligned;
    a64       = 64'(sel_addr);
    slot0_hit = (sel_size == LEN_WIDTH'(SLOT0_SIZE)) && (a64 >= S0_LO) && (a64 < S1_LO);
    slot1_hit = (sel_size == LEN_WIDTH'(SLOT1_SIZE)) && (a64 >= S1_LO) && (a64 < S1_HI);
    aligned   = (sel_addr & ADDR_WIDTH'(PKT_MEM_ALIGNMENT - 1)) == '0;
    entry_ok  = (slot0_hit || slot1_hit) && aligned;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_size_q  <= '0;
      out_msgid_q <= '0;
      rejected_q  <= '0;
    end else begin
      if (hs) rr_q <= (int'(grant) == NUM_SRC - 1) ? '0 : grant + RR_W'(1);
      if (hs && entry_ok) begin
        out_valid_q <= 1'b1;
        out_addr_q  <= sel_addr;
        out_size_q  <= sel_size;
        out_msgid_q <= sel_msgid;
      end else if (bus.feedback_ready_i) begin
        out_valid_q <= 1'b0;
      end
      if (hs && !entry_ok && rejected_q != '1) rejected_q <= rejected_q + 32'd1;
    end
  end

  // Simultaneous alloc and release cancel out.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight_q  <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (alloc_i && !fwd) begin
        if (inflight_q != '1) inflight_q <= inflight_q + INFLIGHT_WIDTH'(1);
      end else if (fwd && !alloc_i) begin
        if (inflight_q == '0) underflow_q <= 1'b1;
        else                  inflight_q  <= inflight_q - INFLIGHT_WIDTH'(1);
      end
    end
  end

  assign bus.feedback_valid_o    = out_valid_q;
  assign bus.feedback_her_addr_o = out_addr_q;
  assign bus.feedback_her_size_o = out_size_q;
  assign bus.feedback_msgid_o    = out_msgid_q;
  assign inflight_o              = inflight_q;
  assign rejected_o              = rejected_q;
  assign underflow_o             = underflow_q;

endmodule

// File: tb/tb_pspin_feedback_arb.sv
// Directed bench for pspin_feedback_arb; forwarded entries are checked against a scoreboard queue.
module tb_pspin_feedback_arb;
  logic        clk = 1'b0;
  logic        rstn;
  logic        alloc;
  logic [31:0] inflight;
  logic [31:0] rejected;
  logic        underflow;

  int checks = 0;
  int errors = 0;
  logic [61:0] exp_q[$];

  always #5 clk = ~clk;

  pspin_feedback_arb_if #(.NUM_SRC(4), .ADDR_WIDTH(32), .LEN_WIDTH(20), .MSGID_WIDTH(10)) bus ();

  pspin_feedback_arb dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus.master),
    .alloc_i    (alloc),
    .inflight_o (inflight),
    .rejected_o (rejected),
    .underflow_o(underflow)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int src, input logic [31:0] a, input logic [19:0] s,
                         input logic [9:0] m);
    bus.fb_her_addr_i[src*32 +: 32] = a;
    bus.fb_her_size_i[src*20 +: 20] = s;
    bus.fb_msgid_i[src*10 +: 10]    = m;
  endtask

  // Returns with the handshake done and the caller positioned just after that edge.
  task automatic send(input int src, input logic [31:0] a, input logic [19:0] s,
                      input logic [9:0] m, input bit push);
    bit got;
    got = 1'b0;
    set_src(src, a, s, m);
    bus.fb_valid_i[src] = 1'b1;
    if (push) exp_q.push_back({a, s, m});
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (bus.fb_ready_o[src]) got = 1'b1;
    end
    if (!got) begin
      errors++;
      checks++;
      $display("FAIL send_timeout src=%0d actual=no_ready required=ready", src);
    end
    tick();
    bus.fb_valid_i[src] = 1'b0;
  endtask

  // Monitor: pop an expectation for every accepted output beat.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn && bus.feedback_valid_o && bus.feedback_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {2'b0, bus.feedback_her_addr_o, bus.feedback_her_size_o,
              bus.feedback_msgid_o}, 64'hDEAD);
        end else begin
          chk("output_entry", {2'b0, bus.feedback_her_addr_o, bus.feedback_her_size_o,
              bus.feedback_msgid_o}, {2'b0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    rstn = 1'b0;
    alloc = 1'b0;
    bus.fb_valid_i = '0;
    bus.fb_her_addr_i = '0;
    bus.fb_her_size_i = '0;
    bus.fb_msgid_i = '0;
    bus.feedback_ready_i = 1'b1;
    #3;
    chk("rst_valid", bus.feedback_valid_o, 0);
    chk("rst_addr", bus.feedback_her_addr_o, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_rejected", rejected, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_fb_ready", bus.fb_ready_o, 0);
    tick();
    rstn = 1'b1;
    tick();

    // Single source with prior allocation.
    alloc = 1'b1; tick(); alloc = 1'b0;
    chk("inflight_after_alloc", inflight, 1);
    send(0, 32'h1c10_0600, 20'd1536, 10'd5, 1'b1);
    chk("latency_valid", bus.feedback_valid_o, 1);
    tick();
    chk("inflight_after_fwd", inflight, 0);
    chk("no_underflow", underflow, 0);

    // Round robin from pointer 0 with all sources valid.
    rstn = 1'b0; #2; rstn = 1'b1; tick();
    alloc = 1'b1;
    repeat (8) tick();
    alloc = 1'b0;
    chk("inflight_8", inflight, 8);
    for (int i = 0; i < 4; i++)
      set_src(i, 32'h1c10_0000 + 32'(i) * 32'h600, 20'd1536, 10'(i + 10));
    for (int c = 0; c < 5; c++)
      exp_q.push_back({32'h1c10_0000 + 32'(c % 4) * 32'h600, 20'd1536, 10'((c % 4) + 10)});
    bus.fb_valid_i = 4'hF;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("rr_grant", bus.fb_ready_o, 64'(4'b0001 << (c % 4)));
      tick();
    end
    bus.fb_valid_i = '0;
    tick(); tick();
    chk("inflight_after_rr", inflight, 3);

    // Backpressure with the output register full.
    bus.feedback_ready_i = 1'b0;
    set_src(1, 32'h1c10_0c00, 20'd1536, 10'd21);
    bus.fb_valid_i[1] = 1'b1;
    exp_q.push_back({32'h1c10_0c00, 20'd1536, 10'd21});
    @(negedge clk);
    chk("bp_first_grant", bus.fb_ready_o, 4'b0010);
    tick();
    bus.fb_valid_i[1] = 1'b0;
    set_src(2, 32'h1c28_0040, 20'd64, 10'd22);
    bus.fb_valid_i[2] = 1'b1;
    exp_q.push_back({32'h1c28_0040, 20'd64, 10'd22});
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_ready_low", bus.fb_ready_o, 0);
      chk("bp_addr_stable", bus.feedback_her_addr_o, 32'h1c10_0c00);
      tick();
    end
    bus.feedback_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_release_grant", bus.fb_ready_o, 4'b0100);
    tick();
    bus.fb_valid_i[2] = 1'b0;
    chk("bp_next_valid", bus.feedback_valid_o, 1);
    chk("bp_next_addr", bus.feedback_her_addr_o, 32'h1c28_0040);
    tick();
    chk("inflight_after_bp", inflight, 1);

    // Invalid entries.
    send(3, 32'h1c10_0000, 20'd1000, 10'd1, 1'b0);
    chk("rej_bad_size", rejected, 1);
    chk("rej_bad_size_noout", bus.feedback_valid_o, 0);
    send(0, 32'h1c10_0000, 20'd64, 10'd2, 1'b0);
    chk("rej_wrong_range", rejected, 2);
    chk("rej_wrong_range_noout", bus.feedback_valid_o, 0);
    send(1, 32'h1c28_0020, 20'd64, 10'd3, 1'b0);
    chk("rej_misaligned", rejected, 3);
    chk("rej_misaligned_noout", bus.feedback_valid_o, 0);
    chk("inflight_unchanged_rej", inflight, 1);

    // Range boundaries.
    alloc = 1'b1; tick(); tick(); alloc = 1'b0;
    send(2, 32'h1c27_fa00, 20'd1536, 10'd30, 1'b1);
    send(3, 32'h1c2f_ffc0, 20'd64, 10'd31, 1'b1);
    send(0, 32'h1c30_0000, 20'd64, 10'd32, 1'b0);
    chk("rej_past_end", rejected, 4);
    tick();
    chk("inflight_after_bounds", inflight, 1);

    // Alloc coinciding with a forward.
    send(1, 32'h1c10_1200, 20'd1536, 10'd40, 1'b1);
    alloc = 1'b1; tick(); alloc = 1'b0;
    chk("inflight_alloc_and_fwd", inflight, 1);

    // Underflow.
    send(2, 32'h1c10_1800, 20'd1536, 10'd41, 1'b1);
    tick();
    chk("inflight_zero", inflight, 0);
    chk("underflow_still_low", underflow, 0);
    send(3, 32'h1c10_1e00, 20'd1536, 10'd42, 1'b1);
    tick();
    chk("underflow_hold_zero", inflight, 0);
    chk("underflow_set", underflow, 1);
    repeat (3) tick();
    chk("underflow_sticky", underflow, 1);

    // Reset with a pending output entry.
    bus.feedback_ready_i = 1'b0;
    send(0, 32'h1c10_2400, 20'd1536, 10'd50, 1'b0);
    chk("pending_before_reset", bus.feedback_valid_o, 1);
    rstn = 1'b0; #2;
    chk("reset_drops_pending", bus.feedback_valid_o, 0);
    chk("reset_clears_rejected", rejected, 0);
    chk("reset_clears_underflow", underflow, 0);
    tick();
    rstn = 1'b1;
    bus.feedback_ready_i = 1'b1;
    repeat (3) tick();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
